// File: rtl/polar_node_seq.sv
// polar_node_seq: sequencer for one polar successive-cancellation node step.
// Holds a 2*N_PAIRS LLR buffer; a cfg handshake issues cfg_len F- or G-ops over
// pairs (llr[i], llr[i+len]) through one shared f/g unit and streams the
// saturated results through a one-entry valid/ready output register.
// Optional build macro: POLAR_HARD_DEC_EN adds the hard_o hard-decision output.
module polar_node_seq #(
  parameter int N_PAIRS  = 4,
  parameter int QTF_SIZE = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          llr_we_i,
  input  logic [$clog2(2*N_PAIRS)-1:0]  llr_addr_i,
  input  logic [QTF_SIZE-1:0]           llr_data_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic                          cfg_mode_i,
  input  logic [$clog2(N_PAIRS):0]      cfg_len_i,
  input  logic [N_PAIRS-1:0]            beta_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [QTF_SIZE-1:0]           out_data_o,
  output logic [$clog2(N_PAIRS)-1:0]    out_idx_o,
  output logic                          busy_o,
  output logic                          done_o
`ifdef POLAR_HARD_DEC_EN
  ,
  output logic                          hard_o
`endif
);

  localparam int AW      = $clog2(2*N_PAIRS);
  localparam int IW      = $clog2(N_PAIRS);
  localparam int LW      = IW + 1;
  localparam int DEPTH   = 2*N_PAIRS;
  localparam int MAG_MAX = (1 << (QTF_SIZE-1)) - 1;

  localparam logic [LW-1:0]          LEN_MAX  = LW'(N_PAIRS);
  localparam logic [QTF_SIZE-1:0]    POS_SAT  = QTF_SIZE'(MAG_MAX);
  localparam logic [QTF_SIZE-1:0]    NEG_SAT  = QTF_SIZE'(-MAG_MAX);
  localparam logic [QTF_SIZE-1:0]    MOST_NEG = {1'b1, {(QTF_SIZE-1){1'b0}}};
  localparam logic signed [QTF_SIZE:0] SUM_HI = (QTF_SIZE+1)'(MAG_MAX);
  localparam logic signed [QTF_SIZE:0] SUM_LO = (QTF_SIZE+1)'(-MAG_MAX);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_reg;
  logic [QTF_SIZE-1:0]   llr_mem [DEPTH];
  logic                  mode_reg;
  logic [LW-1:0]         len_reg;
  logic [LW-1:0]         cnt_reg;
  logic [N_PAIRS-1:0]    beta_reg;
  logic                  out_valid_reg;
  logic [QTF_SIZE-1:0]   out_data_reg;
  logic [IW-1:0]         out_idx_reg;
  logic                  cfg_ready_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic [LW-1:0]         len_clamped;
  logic                  issuing;
  logic                  issue;
  logic [AW-1:0]         a_idx;
  logic [AW-1:0]         b_idx;
  logic [QTF_SIZE-1:0]   a_val, b_val, a_mag, b_mag, f_min, f_res, g_res, op_res;
  logic signed [QTF_SIZE:0] g_sum;

  // |x| with the most negative code folded onto the largest positive magnitude
  function automatic logic [QTF_SIZE-1:0] mag_sat(input logic [QTF_SIZE-1:0] x);
    if (x == MOST_NEG)
      return POS_SAT;
    else if (x[QTF_SIZE-1])
      return -x;
    else
      return x;
  endfunction

  assign len_clamped = (cfg_len_i > LEN_MAX) ? LEN_MAX : cfg_len_i;
  // pairs still to be issued; a new beat may enter when the output slot frees up
  assign issuing     = cnt_reg < len_reg;
  assign issue       = (state_reg == RUN) && issuing && (!out_valid_reg || out_ready_i);
  assign a_idx       = AW'(cnt_reg);
  assign b_idx       = AW'(cnt_reg + len_reg);

  // shared f/g unit: one pair per cycle, results saturated to +/-MAG_MAX
  always_comb begin
    a_val = llr_mem[a_idx];
    b_val = llr_mem[b_idx];
    a_mag = mag_sat(a_val);
    b_mag = mag_sat(b_val);
    f_min = (a_mag < b_mag) ? a_mag : b_mag;
    f_res = (a_val[QTF_SIZE-1] ^ b_val[QTF_SIZE-1]) ? -f_min : f_min;
    if (beta_reg[cnt_reg[IW-1:0]])
      g_sum = $signed({b_val[QTF_SIZE-1], b_val}) - $signed({a_val[QTF_SIZE-1], a_val});
    else
      g_sum = $signed({b_val[QTF_SIZE-1], b_val}) + $signed({a_val[QTF_SIZE-1], a_val});
    if (g_sum > SUM_HI)
      g_res = POS_SAT;
    else if (g_sum < SUM_LO)
      g_res = NEG_SAT;
    else
      g_res = g_sum[QTF_SIZE-1:0];
    op_res = mode_reg ? g_res : f_res;
  end

  // LLR buffer: writable only while idle, so a running pass sees a frozen buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) llr_mem[k] <= '0;
    end else if (llr_we_i && state_reg == IDLE) begin
      llr_mem[llr_addr_i] <= llr_data_i;
    end
  end

  // node-step FSM with registered handshake, status and output-stage signals
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      beta_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_idx_reg   <= '0;
      cfg_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg_valid_i && cfg_ready_reg) begin
            mode_reg      <= cfg_mode_i;
            len_reg       <= len_clamped;
            beta_reg      <= beta_i;
            cnt_reg       <= '0;
            cfg_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (len_clamped == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= op_res;
            out_idx_reg   <= cnt_reg[IW-1:0];
            cnt_reg       <= cnt_reg + LW'(1);
          end else if (out_valid_reg && out_ready_i) begin
            // last beat leaves the slot with nothing left to issue
            out_valid_reg <= 1'b0;
            state_reg     <= DONE;
            done_reg      <= 1'b1;
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          cfg_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
        default: begin
          state_reg     <= IDLE;
          cfg_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

`ifdef POLAR_HARD_DEC_EN
  logic hard_reg;

  // hard decision captured together with each registered beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      hard_reg <= 1'b0;
    else if (issue)
      hard_reg <= op_res[QTF_SIZE-1];
  end

  assign hard_o = hard_reg;
`else
  // no hard-decision output in this build
`endif

  assign cfg_ready_o = cfg_ready_reg;
  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign out_idx_o   = out_idx_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;

endmodule

// File: tb/tb_polar_node_seq.sv
// tb_polar_node_seq: directed + randomized bench for polar_node_seq.
// Expected beats come from an integer model of the F/G rules over a model buffer.
module tb_polar_node_seq;

  localparam int NP = 4;

  logic        clk_i;
  logic        rst_ni;
  logic        llr_we_i;
  logic [2:0]  llr_addr_i;
  logic [7:0]  llr_data_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic        cfg_mode_i;
  logic [2:0]  cfg_len_i;
  logic [3:0]  beta_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_data_o;
  logic [1:0]  out_idx_o;
  logic        busy_o;
  logic        done_o;
`ifdef POLAR_HARD_DEC_EN
  logic        hard_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  int mem [8];

  polar_node_seq #(.N_PAIRS(NP), .QTF_SIZE(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .llr_we_i    (llr_we_i),
    .llr_addr_i  (llr_addr_i),
    .llr_data_i  (llr_data_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_mode_i  (cfg_mode_i),
    .cfg_len_i   (cfg_len_i),
    .beta_i      (beta_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef POLAR_HARD_DEC_EN
    ,
    .hard_o      (hard_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // global time limit so the bench always ends
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int rand_llr();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // integer reference of the node operations
  function automatic int ref_op(input bit mode, input int a, input int b, input bit bt);
    int ma, mb, m, s;
    if (mode == 1'b0) begin
      ma = (a < 0) ? -a : a;
      mb = (b < 0) ? -b : b;
      if (ma > 127) ma = 127;
      if (mb > 127) mb = 127;
      m = (ma < mb) ? ma : mb;
      return ((a < 0) != (b < 0)) ? -m : m;
    end
    s = bt ? (b - a) : (b + a);
    if (s > 127) s = 127;
    if (s < -127) s = -127;
    return s;
  endfunction

  task automatic wr(input int addr, input int val);
    llr_we_i   = 1'b1;
    llr_addr_i = 3'(addr);
    llr_data_i = 8'(val);
    mem[addr]  = val;
    @(negedge clk_i);
    llr_we_i   = 1'b0;
  endtask

  // one complete node step; called and returning at a negedge while idle
  task automatic run_node(input bit mode, input int len_req, input logic [3:0] beta,
                          input int stall_mode, input bit hs_write, input bit busy_write);
    int len, got, stall_cnt, baddr, v;
    int exp_q[$];
    bit fin, held, r;
    logic [7:0] held_data, e8;
    logic [1:0] held_idx;
`ifdef POLAR_HARD_DEC_EN
    logic held_hard;
`endif
    len = (len_req > NP) ? NP : len_req;
    chk("cfg_ready_idle", 32'(cfg_ready_o), 32'd1);
    cfg_valid_i = 1'b1;
    cfg_mode_i  = mode;
    cfg_len_i   = 3'(len_req);
    beta_i      = beta;
    out_ready_i = 1'b1;
    if (hs_write) begin
      v = rand_llr();
      llr_we_i = 1'b1; llr_addr_i = 3'd0; llr_data_i = 8'(v);
      mem[0] = v;
    end
    for (int i = 0; i < len; i++) exp_q.push_back(ref_op(mode, mem[i], mem[i+len], beta[i]));
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    llr_we_i    = 1'b0;
    chk("busy_after_hs", 32'(busy_o), 32'd1);
    chk("cfg_ready_after_hs", 32'(cfg_ready_o), 32'd0);
    chk("no_valid_before_latency", 32'(out_valid_o), 32'd0);
    if (len == 0) begin
      chk("done_len0", 32'(done_o), 32'd1);
      @(negedge clk_i);
      chk("done_len0_single", 32'(done_o), 32'd0);
      chk("cfg_ready_len0_back", 32'(cfg_ready_o), 32'd1);
      chk("busy_len0_clear", 32'(busy_o), 32'd0);
      $display("run mode=%0d len=%0d beats=0", mode, len_req);
      return;
    end
    chk("no_done_at_start", 32'(done_o), 32'd0);
    if (busy_write) begin
      baddr = int'($urandom_range(0, 7));
      llr_we_i = 1'b1; llr_addr_i = 3'(baddr); llr_data_i = ~8'(mem[baddr]);
      cfg_valid_i = 1'b1; cfg_len_i = 3'd0;
    end
    @(negedge clk_i);
    llr_we_i    = 1'b0;
    cfg_valid_i = 1'b0;
    chk("first_beat_latency", 32'(out_valid_o), 32'd1);
    got = 0; stall_cnt = 0; fin = 1'b0; held = 1'b0;
    held_data = '0; held_idx = '0;
`ifdef POLAR_HARD_DEC_EN
    held_hard = 1'b0;
`endif
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (held) begin
        chk("hold_valid", 32'(out_valid_o), 32'd1);
        chk("hold_data", 32'(out_data_o), 32'(held_data));
        chk("hold_idx", 32'(out_idx_o), 32'(held_idx));
`ifdef POLAR_HARD_DEC_EN
        chk("hold_hard", 32'(hard_o), 32'(held_hard));
`endif
      end
      if (stall_mode == 0 && got < len) chk("throughput", 32'(out_valid_o), 32'd1);
      chk("no_early_done", 32'(done_o), 32'd0);
      case (stall_mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: begin
          r = !(out_valid_o && out_idx_o == 2'd1 && stall_cnt < 3);
          if (!r) stall_cnt++;
        end
      endcase
      out_ready_i = r;
      if (out_valid_o && r) begin
        if (got < len) begin
          e8 = 8'(exp_q[got]);
          chk("beat_idx", 32'(out_idx_o), 32'(got));
          chk("beat_data", 32'(out_data_o), 32'(e8));
`ifdef POLAR_HARD_DEC_EN
          chk("beat_hard", 32'(hard_o), 32'(e8[7]));
`endif
          $display("beat mode=%0d idx=%0d data=%0d exp=%0d", mode, out_idx_o,
                   $signed(out_data_o), exp_q[got]);
        end else begin
          chk("extra_beat", 32'(got), 32'(len - 1));
        end
        got++;
        held = 1'b0;
        if (got >= len) fin = 1'b1;
      end else begin
        held      = out_valid_o;
        held_data = out_data_o;
        held_idx  = out_idx_o;
`ifdef POLAR_HARD_DEC_EN
        held_hard = hard_o;
`endif
      end
      @(negedge clk_i);
    end
    out_ready_i = 1'b1;
    if (!fin) chk("beat_count_timeout", 32'(got), 32'(len));
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("valid_low_after_last", 32'(out_valid_o), 32'd0);
    chk("busy_in_done", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    chk("done_single_cycle", 32'(done_o), 32'd0);
    chk("cfg_ready_back", 32'(cfg_ready_o), 32'd1);
    chk("busy_clear", 32'(busy_o), 32'd0);
    chk("no_extra_valid", 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    bit found;
    rst_ni = 1'b0; llr_we_i = 1'b0; llr_addr_i = '0; llr_data_i = '0;
    cfg_valid_i = 1'b0; cfg_mode_i = 1'b0; cfg_len_i = '0; beta_i = '0; out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) mem[k] = 0;
    repeat (2) @(negedge clk_i);
    chk("rst_cfg_ready", 32'(cfg_ready_o), 32'd1);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out_data", 32'(out_data_o), 32'd0);
    chk("rst_out_idx", 32'(out_idx_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
`ifdef POLAR_HARD_DEC_EN
    chk("rst_hard", 32'(hard_o), 32'd0);
`endif
    rst_ni = 1'b1;
    @(negedge clk_i);

    // F pass, len=2 -> -3, +7
    wr(0, 5); wr(1, -20); wr(2, -3); wr(3, -7);
    run_node(1'b0, 2, 4'b0000, 0, 1'b0, 1'b0);
    // G pass, beta=10 -> +127, -127
    wr(0, 100); wr(1, 100); wr(2, 100); wr(3, -100);
    run_node(1'b1, 2, 4'b0010, 0, 1'b0, 1'b0);
    // F with two most-negative inputs -> +127
    wr(0, -128); wr(1, -128);
    run_node(1'b0, 1, 4'b0000, 0, 1'b0, 1'b0);
    // backpressure on beat 1
    for (int k = 0; k < 8; k++) wr(k, rand_llr());
    run_node(1'b0, 4, 4'b0000, 2, 1'b0, 1'b0);
    run_node(1'b1, 4, 4'b1011, 2, 1'b0, 1'b0);
    // len=0 and clamped len=7
    run_node(1'b0, 0, 4'b0000, 0, 1'b0, 1'b0);
    run_node(1'b1, 7, 4'b0101, 0, 1'b0, 1'b0);
    // write on handshake is used; write/cfg while busy are ignored
    run_node(1'b1, 3, 4'b0110, 0, 1'b1, 1'b1);
    run_node(1'b0, 4, 4'b0000, 0, 1'b0, 1'b0);
    run_node(1'b1, 4, 4'b1100, 1, 1'b0, 1'b1);
    run_node(1'b1, 4, 4'b0011, 0, 1'b0, 1'b0);

    // randomized node steps
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 8; k++) wr(k, rand_llr());
      run_node(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a len=4 run
    for (int k = 0; k < 8; k++) wr(k, rand_llr() | 1);
    cfg_valid_i = 1'b1; cfg_mode_i = 1'b0; cfg_len_i = 3'd4; beta_i = 4'd0; out_ready_i = 1'b1;
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk_i);
      if (out_valid_o && out_idx_o == 2'd1) found = 1'b1;
    end
    chk("reach_beat1", 32'(found), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_cfg_ready", 32'(cfg_ready_o), 32'd1);
    chk("midrst_data", 32'(out_data_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("midrst_no_done", 32'(done_o), 32'd0);
    end
    rst_ni = 1'b1;
    for (int k = 0; k < 8; k++) mem[k] = 0;
    @(negedge clk_i);
    $display("reset mid-run applied and released");
    // cleared buffer: every beat must be zero
    run_node(1'b0, 4, 4'b0000, 0, 1'b0, 1'b0);
    run_node(1'b1, 4, 4'b1010, 1, 1'b0, 1'b0);
    wr(1, -50); wr(5, 30);
    run_node(1'b1, 4, 4'b0010, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
